hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard and halt controller for the 5-stage RISC-V core. It reads the stage fields carried by the IF/ID, ID/EX, EX/MEM and MEM/WB buffer registers (`Pipe_Buf_Reg_PKG`). From them it produces:
- write enables and flushes that steer those registers,
- forwarding selects for the EX-stage ALU operands,
- a halt sequencer that drains the pipeline once `HaltSel` enters EX.

Saturating stall and flush counters are exposed for debug and performance checks.

## Interface
- `CNT_W`, 16, width of the stall and flush event counters.

- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ifid_rs1`  in  5  IF/ID `Curr_Instr[19:15]`.
- `ifid_rs2`  in  5  IF/ID `Curr_Instr[24:20]`.
- `idex_rs1`  in  5  ID/EX `RS_One`.
- `idex_rs2`  in  5  ID/EX `RS_Two`.
- `idex_rd`  in  5  ID/EX `rd`.
- `idex_memread`  in  1  ID/EX `MemRead`.
- `idex_halt`  in  1  ID/EX `HaltSel`.
- `exmem_rd`  in  5  EX/MEM `rd`.
- `exmem_regwrite`  in  1  EX/MEM `RegWrite`.
- `memwb_rd`  in  5  MEM/WB `rd`.
- `memwb_regwrite`  in  1  MEM/WB `RegWrite`.
- `memwb_halt`  in  1  MEM/WB `HaltSel`.
- `branch_taken`  in  1  EX-stage redirect (taken branch, JAL or JALR).
- `pc_write`  out  1  PC register load enable.
- `ifid_write`  out  1  IF/ID load enable.
- `ifid_flush`  out  1  load zero bubble into IF/ID.
- `idex_flush`  out  1  load zero bubble into ID/EX.
- `fwd_a`  out  2  operand A select: 00 = `RD_One`, 01 = MEM/WB writeback value, 10 = EX/MEM `Alu_Result`.
- `fwd_b`  out  2  operand B select, same encoding against `RD_Two`.
- `halted`  out  1  pipeline fully drained after halt.
- `stall_cnt`  out  `CNT_W`  load-use stall cycles since reset, saturating.
- `flush_cnt`  out  `CNT_W`  branch-flush cycles since reset, saturating.

## Operation
- **Forwarding** (combinational, computed per operand X ∈ {rs1, rs2}):
  - 10 if `exmem_regwrite` && `exmem_rd` != 0 && `exmem_rd` == `idex_rsX`.
  - else 01 if `memwb_regwrite` && `memwb_rd` != 0 && `memwb_rd` == `idex_rsX`.
  - else 00.
  - EX/MEM wins when both stages match.
  - Forwarding is active in every state.
- **Load-use hazard** (`lu`): `idex_memread` && `idex_rd` != 0 && (`idex_rd` == `ifid_rs1` || `idex_rd` == `ifid_rs2`).
- **State machine** with states RUN, DRAIN and HALTED.
  - **RUN**, evaluated in priority order:
    1. `idex_halt`: `pc_write`=0, `ifid_write`=0, `ifid_flush`=1, `idex_flush`=1. Next state is DRAIN. `branch_taken` and `lu` are ignored.
    2. `branch_taken`: `pc_write`=1, `ifid_flush`=1, `idex_flush`=1, `flush_cnt`++. `lu` is ignored because the ID instruction is wrong-path.
    3. `lu`: `pc_write`=0, `ifid_write`=0, `idex_flush`=1, `stall_cnt`++.
    4. Otherwise: `pc_write`=1, `ifid_write`=1, both flushes 0.
  - **DRAIN**:
    - `pc_write`=0, `ifid_write`=0, `ifid_flush`=1, `idex_flush`=1.
    - EX/MEM and MEM/WB keep advancing.
    - Next state is HALTED when `memwb_halt`=1.
  - **HALTED**:
    - Same outputs as DRAIN.
    - `halted`=1.
    - Sticky until `reset`.
- Counters saturate at 2^`CNT_W`−1 and never wrap. Counters do not increment in DRAIN or HALTED.
- A flush takes precedence over a write enable on the same register: the bubble is loaded.

## Timing
- `pc_write`, `ifid_write`, `ifid_flush`, `idex_flush`, `fwd_a` and `fwd_b` are combinational from the current state and inputs. Zero-cycle latency, sampled by the pipeline registers on the same edge.
- `halted` and the counters are registered. They update on the edge that ends the qualifying cycle.
- A load-use stall lasts exactly one cycle. The next cycle, ID/EX holds the bubble, so `idex_memread`=0.
- Halt sequence:
  - Halt is in EX in cycle N (`idex_halt`=1).
  - DRAIN starts in cycle N+1.
  - `memwb_halt`=1 in cycle N+2.
  - `halted`=1 from cycle N+3 onward.
- **Reset** (synchronous, sampled on a rising `clk` edge with `reset`=1):
  - State goes to RUN; `halted`=0, `stall_cnt`=0, `flush_cnt`=0.
  - While `reset` is high the outputs are: `pc_write`=1, `ifid_write`=1, flushes 0, `fwd_a`/`fwd_b` 00.
  - Reset in DRAIN or HALTED returns to RUN on the next edge.
- `rd`=0 never triggers a stall or forward, even with `RegWrite`/`MemRead` set.

## Test plan
- **Forward priority:** `idex_rs1`=5, `exmem_rd`=5 with `exmem_regwrite`=1, `memwb_rd`=5 with `memwb_regwrite`=1 -> `fwd_a`=10. Drop `exmem_regwrite` -> `fwd_a`=01. Set `idex_rs2`=0 with all rd=0 -> `fwd_b`=00.
- **Load-use:** `idex_memread`=1, `idex_rd`=7, `ifid_rs2`=7 -> one cycle with `pc_write`=0, `ifid_write`=0, `idex_flush`=1; `stall_cnt` goes 0→1. The next cycle with `idex_memread`=0 -> normal flow.
- **Branch over load-use:** `branch_taken`=1 together with a load-use match -> `pc_write`=1, `ifid_flush`=1, `idex_flush`=1; `flush_cnt`=1, `stall_cnt` unchanged.
- **Halt drain:** `idex_halt`=1 in cycle 10, `memwb_halt`=1 in cycle 12 -> DRAIN outputs in cycles 10–12, `halted`=1 from cycle 13. `branch_taken`=1 during DRAIN -> no counter change.
- **Counter saturation:** with `CNT_W`=2, hold load-use for 5 stall events -> `stall_cnt` stops at 3.
- **Reset mid-drain:** `reset`=1 while in DRAIN -> after the edge `halted`=0, counters 0, `pc_write`=1.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard, forwarding and halt-drain controller
// Steers the IF/ID and ID/EX buffer registers and the PC, selects EX operand sources.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic [4:0]       idex_rs1,
  input  logic [4:0]       idex_rs2,
  input  logic [4:0]       idex_rd,
  input  logic             idex_memread,
  input  logic             idex_halt,
  input  logic [4:0]       exmem_rd,
  input  logic             exmem_regwrite,
  input  logic [4:0]       memwb_rd,
  input  logic             memwb_regwrite,
  input  logic             memwb_halt,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } state_t;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t state;
  state_t state_nxt;

  logic lu;
  logic stall_inc;
  logic flush_inc;

  // The younger producer (EX/MEM) is checked first so it wins over MEM/WB.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] ex_rd,
    input logic       ex_wr,
    input logic [4:0] wb_rd,
    input logic       wb_wr
  );
    if (ex_wr && (ex_rd != 5'd0) && (ex_rd == rs)) begin
      return FWD_EXMEM;
    end else if (wb_wr && (wb_rd != 5'd0) && (wb_rd == rs)) begin
      return FWD_MEMWB;
    end else begin
      return FWD_RF;
    end
  endfunction

  assign lu = idex_memread && (idex_rd != 5'd0) &&
              ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));

  always_comb begin
    if (reset) begin
      fwd_a = FWD_RF;
      fwd_b = FWD_RF;
    end else begin
      fwd_a = fwd_sel(idex_rs1, exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite);
      fwd_b = fwd_sel(idex_rs2, exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite);
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    if (!reset) begin
      case (state)
        RUN: begin
          if (idex_halt) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_nxt  = DRAIN;
          end else if (branch_taken) begin
            // The ID instruction is wrong-path, so a load-use match is moot.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_inc  = 1'b1;
          end else if (lu) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            stall_inc  = 1'b1;
          end
        end
        DRAIN: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          if (memwb_halt) begin
            state_nxt = HALTED;
          end
        end
        HALTED: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      halted    <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state  <= state_nxt;
      halted <= (state_nxt == HALTED);
      if (stall_inc && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
      if (flush_inc && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end
    end
  end

endmodule
